// File: rtl/maj_fold_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maj_fold_pkg
// Brief    : Shared types and helpers for the folded majority sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package maj_fold_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width needed to hold any count in 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] s;
        s = '0;
        for (int i = 0; i < 64; i++) begin
            s = s + {6'd0, v[i]};
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maj_chunk_popcount.sv
`default_nettype none
// ============================================================================
// Module   : maj_chunk_popcount
// Brief    : Combinational ones-count of one CHUNK-bit slice.
// Revision : 1.0 - initial release
// ============================================================================
module maj_chunk_popcount
    import maj_fold_pkg::*;
#(
    parameter int CHUNK = 5,
    parameter int PW    = cnt_width(CHUNK)
) (
    input  logic [CHUNK-1:0] i_bits,
    output logic [PW-1:0]    o_count
);

    assign o_count = PW'(popcount64(64'(i_bits)));

endmodule
`default_nettype wire

// File: rtl/maj_fold_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : maj_fold_sequencer
// Brief    : Folded N-input majority evaluator, one CHUNK slice per cycle.
//            Optional macro MAJ_EARLY_EXIT_EN ends accumulation once decided.
// Revision : 1.0 - initial release
// ============================================================================
module maj_fold_sequencer
    import maj_fold_pkg::*;
#(
    parameter int N      = 15,
    parameter int CHUNK  = 5,
    parameter int THRESH = (N + 1) / 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_y,
    output logic [cnt_width(N)-1:0] out_count
);

    localparam int NCHUNK = (N + CHUNK - 1) / CHUNK;
    localparam int CW     = cnt_width(N);
    localparam int PW     = cnt_width(CHUNK);
    localparam int SW     = NCHUNK * CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] C_THRESH = CW'(THRESH);
    localparam logic [IW-1:0] C_LAST   = IW'(NCHUNK - 1);

    state_t          r_state;
    logic [SW-1:0]   r_sh;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_acc;
    logic            r_out_valid;
    logic            r_out_y;
    logic [CW-1:0]   r_out_count;

    logic [PW-1:0]   w_pc;
    logic [CW-1:0]   w_acc_next;
    logic            w_exit;

    maj_chunk_popcount #(
        .CHUNK (CHUNK)
    ) u_popcount (
        .i_bits  (r_sh[CHUNK-1:0]),
        .o_count (w_pc)
    );

    assign w_acc_next = r_acc + CW'(w_pc);

`ifdef MAJ_EARLY_EXIT_EN
    localparam int RW = CW + 1;
    logic [15:0]   w_seen;
    logic [RW-1:0] w_rem;

    // Bits still unseen after this slice; the decision is final once the
    // remaining bits can neither reach nor lose the threshold.
    assign w_seen = (16'(r_idx) + 16'd1) * 16'(CHUNK);
    assign w_rem  = (w_seen >= 16'(N)) ? '0 : RW'(16'(N) - w_seen);
    assign w_exit = (r_idx == C_LAST)
                 || (w_acc_next >= C_THRESH)
                 || (({1'b0, w_acc_next} + w_rem) < {1'b0, C_THRESH});
`else
    assign w_exit = (r_idx == C_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sh        <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_y     <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sh    <= SW'(in_x);
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_acc <= w_acc_next;
                    r_sh  <= r_sh >> CHUNK;
                    r_idx <= r_idx + IW'(1);
                    if (w_exit) begin
                        r_out_count <= w_acc_next;
                        r_out_y     <= (w_acc_next >= C_THRESH);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = !rst && (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_maj_fold_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_maj_fold_sequencer
// Brief    : Scoreboard bench for maj_fold_sequencer with default parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maj_fold_sequencer;

    localparam int N      = 15;
    localparam int CHUNK  = 5;
    localparam int THRESH = 8;
    localparam int NCHUNK = 3;
    localparam int CW     = 4;

    typedef struct {
        logic [N-1:0] x;
        int           y;
        int           cnt;
        int           lat;
        int           acc_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_x = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_y;
    logic [CW-1:0] out_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_hs     = 0;
    int   hs_cyc   = 0;
    int   last_acc = 0;
    int   last_lat = 0;
    bit   have_prev = 1'b0;
    bit   tp_on    = 1'b0;
    bit   rand_rdy = 1'b0;
    bit   prev_valid = 1'b0;
    exp_t sb[$];

    maj_fold_sequencer #(
        .N      (N),
        .CHUNK  (CHUNK),
        .THRESH (THRESH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference: chunked ones count, optionally stopping once decided.
    function automatic void model(input logic [N-1:0] x, output int y,
                                  output int cnt, output int lat);
        int acc;
        acc = 0;
        lat = NCHUNK;
        for (int i = 1; i <= NCHUNK; i++) begin
            for (int b = (i - 1) * CHUNK; b < i * CHUNK && b < N; b++)
                acc += int'(x[b]);
            lat = i;
`ifdef MAJ_EARLY_EXIT_EN
            begin
                int rem;
                rem = N - ((i * CHUNK > N) ? N : i * CHUNK);
                if (acc >= THRESH || acc + rem < THRESH) break;
            end
`endif
        end
        cnt = acc;
        y   = (acc >= THRESH) ? 1 : 0;
    endfunction

    task automatic send(input logic [N-1:0] x);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", int'(in_ready), 1);
        end else begin
            in_valid = 1'b1;
            in_x     = x;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_x     = N'($urandom);
            e.x = x;
            model(x, e.y, e.cnt, e.lat);
            e.acc_cyc = cyc;
            if (tp_on && have_prev)
                check("throughput", cyc - last_acc, last_lat + 2);
            have_prev = 1'b1;
            last_acc  = cyc;
            last_lat  = e.lat;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("sb_drain", sb.size(), 0);
    endtask

    // Output monitor: latency on the rising edge of out_valid, value on handshake.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) check("unexpected_valid", int'(out_valid), 0);
                else check("latency", cyc - sb[0].acc_cyc, sb[0].lat);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("out_y", int'(out_y), e.y);
                check("out_count", int'(out_count), e.cnt);
                n_hs++;
                hs_cyc = cyc;
            end
        end
        prev_valid = out_valid;
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        logic [N-1:0] dir_vec [5];
        int by, bc, bl, h0, t;
        dir_vec[0] = 15'h0000;
        dir_vec[1] = 15'h7FFF;
        dir_vec[2] = 15'h00FF;
        dir_vec[3] = 15'h007F;
        dir_vec[4] = 15'h5555;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_out_count", int'(out_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;

        // Directed patterns and random vectors, back-to-back at full rate.
        tp_on = 1'b1;
        for (int i = 0; i < 5; i++) send(dir_vec[i]);
        for (int i = 0; i < 30; i++) send(N'($urandom));
        tp_on = 1'b0;
        have_prev = 1'b0;
        wait_drain();

        // Backpressure: hold DONE for five cycles.
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        send(15'h00FF);
        model(15'h00FF, by, bc, bl);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            check("bp_valid", int'(out_valid), 1);
            check("bp_y", int'(out_y), by);
            check("bp_count", int'(out_count), bc);
            check("bp_in_ready", int'(in_ready), 0);
        end
        h0 = n_hs;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        send(15'h007F);
        check("bp_one_handshake", n_hs, h0 + 1);
        check("bp_reaccept", last_acc, hs_cyc + 2);
        wait_drain();

        // Reset after the first slice has been accumulated.
        send(15'h7FFF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_count", int'(out_count), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);
        send(15'h5555);
        wait_drain();

        // Random vectors with random downstream stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1500; i++) send(N'($urandom));
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
